// File: rtl/apb4_gpio_flt_pkg.sv
// Shared definitions for the filtered APB4 GPIO block: word offsets within the
// register window and the encoding of the per-pin interrupt mode.
package gpio_flt_pkg;

    localparam logic [3:0] GPIO_PADDIR   = 4'h0;
    localparam logic [3:0] GPIO_PADIN    = 4'h1;
    localparam logic [3:0] GPIO_PADOUT   = 4'h2;
    localparam logic [3:0] GPIO_PADSET   = 4'h3;
    localparam logic [3:0] GPIO_PADCLR   = 4'h4;
    localparam logic [3:0] GPIO_PADTOG   = 4'h5;
    localparam logic [3:0] GPIO_INTEN    = 4'h6;
    localparam logic [3:0] GPIO_INTMODE0 = 4'h7;
    localparam logic [3:0] GPIO_INTMODE1 = 4'h8;
    localparam logic [3:0] GPIO_INTANY   = 4'h9;
    localparam logic [3:0] GPIO_INTPEND  = 4'hA;
    localparam logic [3:0] GPIO_IOFCFG   = 4'hB;
    localparam logic [3:0] GPIO_FLTEN    = 4'hC;
    localparam logic [3:0] GPIO_FLTDIV   = 4'hD;

    // Encoding is {INTMODE1[i], INTMODE0[i]}.
    typedef enum logic [1:0] {
        LVL_HI = 2'b00,
        LVL_LO = 2'b01,
        RISE   = 2'b10,
        FALL   = 2'b11
    } intmode_e;

endpackage

// File: rtl/apb4_gpio_flt_if.sv
// APB4 completer-side signal bundle for the GPIO block.
interface apb4_gpio_flt_if;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb4_gpio_flt_pin.sv
// One GPIO input lane: synchroniser, debounce counter and the stable/prev pair
// that turns the filtered level into single-cycle edge strobes.
module gpio_flt_pin #(
    parameter int SYNC_STAGES = 2,
    parameter int FLT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pad,
    input  logic                 flt_en,
    input  logic [FLT_WIDTH-1:0] flt_div,
    output logic                 stable,
    output logic                 rise,
    output logic                 fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   raw;
    logic                   prev;
    logic [FLT_WIDTH-1:0]   cnt;

    assign raw  = sync[SYNC_STAGES-1];
    assign rise = stable & ~prev;
    assign fall = ~stable & prev;

    // >= rather than == so a threshold lowered mid-count still accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            stable <= 1'b0;
            prev   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad};
            prev <= stable;
            if (!flt_en) begin
                stable <= raw;
            end else if (raw == stable) begin
                cnt <= '0;
            end else if (cnt >= flt_div) begin
                stable <= raw;
                cnt    <= '0;
            end else begin
                cnt <= cnt + FLT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/apb4_gpio_flt.sv
// APB4 GPIO with per-pin debounce, atomic PADOUT set/clear/toggle and sticky
// W1C interrupt pending bits combined into one registered interrupt line.
module apb4_gpio_flt
    import gpio_flt_pkg::*;
#(
    parameter int GPIO_NUM    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FLT_WIDTH   = 8
) (
    input  logic                pclk,
    input  logic                prst,
    apb4_gpio_flt_if.slave      apb,
    input  logic [GPIO_NUM-1:0] gpio_in_i,
    output logic [GPIO_NUM-1:0] gpio_out_o,
    output logic [GPIO_NUM-1:0] gpio_dir_o,
    output logic [GPIO_NUM-1:0] gpio_iof_o,
    output logic                irq_o
);

    logic [3:0]           addr;
    logic                 wr, rd, bad;
    logic [GPIO_NUM-1:0]  wdata;
    logic [GPIO_NUM-1:0]  dir, pad_out, inten, mode0, mode1, any, pend, iof, flten;
    logic [FLT_WIDTH-1:0] fltdiv;
    logic [GPIO_NUM-1:0]  stable, rise, fall, evt, pend_clr, pend_nxt;
    logic [31:0]          rdata;
    logic                 unused_addr;

    assign addr        = apb.paddr[5:2];
    assign unused_addr = ^{apb.paddr[31:6], apb.paddr[1:0]};
    assign wr          = apb.psel & apb.penable & apb.pwrite;
    assign rd          = apb.psel & apb.penable & ~apb.pwrite;
    assign bad         = (addr[3:1] == 3'b111);
    assign wdata       = apb.pwdata[GPIO_NUM-1:0];

    assign apb.pready  = 1'b1;
    assign apb.pslverr = apb.psel & apb.penable & bad;
    assign apb.prdata  = rd ? rdata : '0;

    assign gpio_out_o = pad_out;
    assign gpio_dir_o = dir;
    assign gpio_iof_o = iof;

    for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
        gpio_flt_pin #(
            .SYNC_STAGES(SYNC_STAGES),
            .FLT_WIDTH  (FLT_WIDTH)
        ) u_pin (
            .clk    (pclk),
            .rst    (prst),
            .pad    (gpio_in_i[i]),
            .flt_en (flten[i]),
            .flt_div(fltdiv),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    always_comb begin
        evt = '0;
        for (int i = 0; i < GPIO_NUM; i++) begin
            if (any[i]) begin
                evt[i] = rise[i] | fall[i];
            end else begin
                case (intmode_e'({mode1[i], mode0[i]}))
                    LVL_HI:  evt[i] = stable[i];
                    LVL_LO:  evt[i] = ~stable[i];
                    RISE:    evt[i] = rise[i];
                    default: evt[i] = fall[i];
                endcase
            end
        end
    end

    // A new event in the same cycle as a W1C keeps the bit set.
    assign pend_clr = (wr && addr == GPIO_INTPEND) ? wdata : '0;
    assign pend_nxt = (pend & ~pend_clr) | (inten & evt);

    always_comb begin
        rdata = '0;
        case (addr)
            GPIO_PADDIR:   rdata = 32'(dir);
            GPIO_PADIN:    rdata = 32'(stable);
            GPIO_PADOUT:   rdata = 32'(pad_out);
            GPIO_INTEN:    rdata = 32'(inten);
            GPIO_INTMODE0: rdata = 32'(mode0);
            GPIO_INTMODE1: rdata = 32'(mode1);
            GPIO_INTANY:   rdata = 32'(any);
            GPIO_INTPEND:  rdata = 32'(pend);
            GPIO_IOFCFG:   rdata = 32'(iof);
            GPIO_FLTEN:    rdata = 32'(flten);
            GPIO_FLTDIV:   rdata = 32'(fltdiv);
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            dir     <= '0;
            pad_out <= '0;
            inten   <= '0;
            mode0   <= '0;
            mode1   <= '0;
            any     <= '0;
            pend    <= '0;
            iof     <= '0;
            flten   <= '0;
            fltdiv  <= '0;
            irq_o   <= 1'b0;
        end else begin
            pend  <= pend_nxt;
            irq_o <= |(pend & inten);
            if (wr && !bad) begin
                case (addr)
                    GPIO_PADDIR:   dir     <= wdata;
                    GPIO_PADOUT:   pad_out <= wdata;
                    GPIO_PADSET:   pad_out <= pad_out | wdata;
                    GPIO_PADCLR:   pad_out <= pad_out & ~wdata;
                    GPIO_PADTOG:   pad_out <= pad_out ^ wdata;
                    GPIO_INTEN:    inten   <= wdata;
                    GPIO_INTMODE0: mode0   <= wdata;
                    GPIO_INTMODE1: mode1   <= wdata;
                    GPIO_INTANY:   any     <= wdata;
                    GPIO_IOFCFG:   iof     <= wdata;
                    GPIO_FLTEN:    flten   <= wdata;
                    GPIO_FLTDIV:   fltdiv  <= apb.pwdata[FLT_WIDTH-1:0];
                    default:       ;
                endcase
            end
        end
    end

endmodule
